// File: rtl/useq_sequencer_if.sv
// Bundle between the microcode sequencer and its IR / microcode ROM / datapath neighbours.
// master = sequencer side, slave = environment (IR, ROM, condition sources) side.
interface useq_sequencer_if #(
  parameter int OPW   = 6,
  parameter int UAW   = 8,
  parameter int UWW   = 48,
  parameter int NCOND = 4
);
  localparam int CSW = $clog2(NCOND);
  localparam int CTW = UWW - 3 - CSW - UAW;

  logic [OPW-1:0]   opcode;
  logic             instr_valid;
  logic             instr_ack;
  logic [NCOND-1:0] cond;
  logic             irq;
  logic             fault;
  logic             cont;
  logic [UAW-1:0]   uaddr;
  logic [UWW-1:0]   uword;
  logic [CTW-1:0]   ctrl;
  logic             ctrl_valid;
  logic             halted;
  logic             stack_err;

  modport master (
    input  opcode, instr_valid, cond, irq, fault, cont, uword,
    output instr_ack, uaddr, ctrl, ctrl_valid, halted, stack_err
  );

  modport slave (
    output opcode, instr_valid, cond, irq, fault, cont, uword,
    input  instr_ack, uaddr, ctrl, ctrl_valid, halted, stack_err
  );
endinterface

// File: rtl/useq_sequencer.sv
// Microcode sequencer: advances the micro-PC from the sequencing field of each microword.
// Define USEQ_USTACK_EN to build the micro-subroutine stack (CALL/RET); otherwise CALL=JUMP, RET=NEXT.
module useq_sequencer #(
  parameter int          OPW         = 6,
  parameter int          UAW         = 8,
  parameter int          UWW         = 48,
  parameter int          NCOND       = 4,
  parameter int          STACK_DEPTH = 4,
  parameter int unsigned RESET_VEC   = 0,
  parameter int unsigned IRQ_VEC     = 1,
  parameter int unsigned FAULT_VEC   = 2
) (
  input logic               clk,
  input logic               reset,
  useq_sequencer_if.master  bus
);
  localparam int CSW = $clog2(NCOND);
  localparam int CTW = UWW - 3 - CSW - UAW;

  typedef enum logic [2:0] {
    OP_NEXT     = 3'd0,
    OP_JUMP     = 3'd1,
    OP_CBR      = 3'd2,
    OP_DISPATCH = 3'd3,
    OP_WAIT     = 3'd4,
    OP_CALL     = 3'd5,
    OP_RET      = 3'd6,
    OP_HALT     = 3'd7
  } op_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // Empty block that only elaborates on an illegal parameter set, easy to spot in a hierarchy dump.
  if (UWW < 4 + CSW + UAW || STACK_DEPTH < 1) begin : g_bad_params
  end

  state_e         r_state;
  state_e         w_state_next;
  logic [UAW-1:0] r_upc;
  logic [UAW-1:0] w_upc_next;
  logic           r_stack_err;
  logic           w_stack_err_next;
  logic           w_ack;
  logic           w_ctrl_valid;

  op_e            w_op;
  logic [CSW-1:0] w_sel;
  logic [UAW-1:0] w_tgt;
  logic [UAW-1:0] w_upc_inc;
  logic [UAW-1:0] w_disp_addr;
  logic           w_cond_sel;
  logic           w_stack_fault;

  assign w_op        = op_e'(bus.uword[2:0]);
  assign w_sel       = bus.uword[3 +: CSW];
  assign w_tgt       = bus.uword[3 + CSW +: UAW];
  assign w_upc_inc   = r_upc + UAW'(1);
  assign w_disp_addr = w_tgt + UAW'(bus.opcode);
  assign w_cond_sel  = bus.cond[w_sel];

`ifdef USEQ_USTACK_EN
  localparam int SPW  = $clog2(STACK_DEPTH + 1);
  localparam int IDXW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [UAW-1:0]  r_stack [STACK_DEPTH];
  logic [SPW-1:0]  r_sp;
  logic [SPW-1:0]  w_sp_next;
  logic            w_push;
  logic [IDXW-1:0] w_push_idx;
  logic [IDXW-1:0] w_top_idx;
  logic [UAW-1:0]  w_top;
  logic            w_stack_full;
  logic            w_stack_empty;

  assign w_stack_full  = (r_sp == SPW'(STACK_DEPTH));
  assign w_stack_empty = (r_sp == '0);
  assign w_push_idx    = IDXW'(r_sp);
  assign w_top_idx     = IDXW'(r_sp - SPW'(1));
  assign w_top         = r_stack[w_top_idx];
  assign w_stack_fault = ((w_op == OP_CALL) && w_stack_full) ||
                         ((w_op == OP_RET)  && w_stack_empty);

  // Entries carry no reset: the pointer alone defines what is live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[w_push_idx] <= w_upc_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sp <= '0;
    end else begin
      r_sp <= w_sp_next;
    end
  end
`else
  assign w_stack_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_upc       <= UAW'(RESET_VEC);
      r_state     <= ST_RUN;
      r_stack_err <= 1'b0;
    end else begin
      r_upc       <= w_upc_next;
      r_state     <= w_state_next;
      r_stack_err <= w_stack_err_next;
    end
  end

  always_comb begin
    w_upc_next       = r_upc;
    w_state_next     = r_state;
    w_stack_err_next = r_stack_err;
    w_ack            = 1'b0;
    w_ctrl_valid     = 1'b1;
`ifdef USEQ_USTACK_EN
    w_sp_next        = r_sp;
    w_push           = 1'b0;
`endif
    if (bus.fault) begin
      w_upc_next   = UAW'(FAULT_VEC);
      w_state_next = ST_RUN;
      w_ctrl_valid = 1'b0;
`ifdef USEQ_USTACK_EN
      w_sp_next    = '0;
`endif
    end else if (w_stack_fault) begin
      w_upc_next       = UAW'(FAULT_VEC);
      w_stack_err_next = 1'b1;
      w_ctrl_valid     = 1'b0;
    end else begin
      unique case (w_op)
        OP_NEXT: w_upc_next = w_upc_inc;
        OP_JUMP: w_upc_next = w_tgt;
        OP_CBR:  w_upc_next = w_cond_sel ? w_tgt : w_upc_inc;
        OP_DISPATCH: begin
          // An interrupt steals the dispatch slot; the opcode stays unconsumed for later.
          if (!bus.instr_valid) begin
            w_ctrl_valid = 1'b0;
          end else if (bus.irq) begin
            w_upc_next = UAW'(IRQ_VEC);
          end else begin
            w_upc_next = w_disp_addr;
            w_ack      = 1'b1;
          end
        end
        OP_WAIT: begin
          if (w_cond_sel) begin
            w_upc_next = w_upc_inc;
          end else begin
            w_ctrl_valid = 1'b0;
          end
        end
        OP_CALL: begin
          w_upc_next = w_tgt;
`ifdef USEQ_USTACK_EN
          w_push     = 1'b1;
          w_sp_next  = r_sp + SPW'(1);
`endif
        end
        OP_RET: begin
`ifdef USEQ_USTACK_EN
          w_upc_next = w_top;
          w_sp_next  = r_sp - SPW'(1);
`else
          w_upc_next = w_upc_inc;
`endif
        end
        OP_HALT: begin
          w_ctrl_valid = 1'b0;
          if (bus.cont) begin
            w_upc_next   = w_upc_inc;
            w_state_next = ST_RUN;
          end else begin
            w_state_next = ST_HALT;
          end
        end
        default: w_upc_next = w_upc_inc;
      endcase
    end
  end

  assign bus.uaddr      = r_upc;
  assign bus.ctrl       = bus.uword[UWW-1 -: CTW];
  assign bus.ctrl_valid = w_ctrl_valid;
  assign bus.instr_ack  = w_ack;
  assign bus.halted     = (r_state == ST_HALT);
  assign bus.stack_err  = r_stack_err;
endmodule
